resp_fifo_wr_sched: RTL and testbench

//  Schedules writes into the TX FIFO from two response sources: 1-byte register-file read data and 2-byte ALU results.

---
 rtl/resp_fifo_wr_sched_pkg.sv | 22 ++
 rtl/resp_fifo_wr_sched_if.sv | 26 ++
 rtl/resp_fifo_wr_sched_resp_slot.sv | 48 ++++
 rtl/resp_fifo_wr_sched.sv | 103 ++++++++++
 tb/tb_resp_fifo_wr_sched.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/resp_fifo_wr_sched_pkg.sv
// Shared encodings for the response FIFO write scheduler: FSM states, round-robin pointer values,
// and the idle-state source selection.
package resp_fifo_wr_sched_pkg;

  localparam logic [1:0] StIdle      = 2'b00;
  localparam logic [1:0] StSendRf    = 2'b01;
  localparam logic [1:0] StSendAluLo = 2'b10;
  localparam logic [1:0] StSendAluHi = 2'b11;

  // The pointer names the source that was served most recently.
  localparam logic PtrRf  = 1'b0;
  localparam logic PtrAlu = 1'b1;

  // On a tie, serve the source that was not served last.
  function automatic logic [1:0] idle_pick(input logic rf_v, input logic alu_v, input logic ptr);
    if (rf_v && alu_v) return (ptr == PtrAlu) ? StSendRf : StSendAluLo;
    if (rf_v) return StSendRf;
    if (alu_v) return StSendAluLo;
    return StIdle;
  endfunction

endpackage

// File: rtl/resp_fifo_wr_sched_if.sv
// Response-source and TX FIFO write-port bundle for the write scheduler.
interface resp_fifo_wr_sched_if #(
  parameter int unsigned FRAME_WIDTH    = 8,
  parameter int unsigned ALU_DATA_WIDTH = 16
);
  logic [FRAME_WIDTH-1:0]    RF_DATA;
  logic                      RF_VLD;
  logic                      RF_BUSY;
  logic [ALU_DATA_WIDTH-1:0] ALU_DATA;
  logic                      ALU_VLD;
  logic                      ALU_BUSY;
  logic                      FIFO_FULL;
  logic [FRAME_WIDTH-1:0]    WR_DATA;
  logic                      WR_INC;
  logic                      OVF_ERR;

  modport master (
    output RF_DATA, RF_VLD, ALU_DATA, ALU_VLD, FIFO_FULL,
    input  RF_BUSY, ALU_BUSY, WR_DATA, WR_INC, OVF_ERR
  );

  modport slave (
    input  RF_DATA, RF_VLD, ALU_DATA, ALU_VLD, FIFO_FULL,
    output RF_BUSY, ALU_BUSY, WR_DATA, WR_INC, OVF_ERR
  );
endinterface

// File: rtl/resp_fifo_wr_sched_resp_slot.sv
// One response holding slot: captures data when empty, flags an overflow when a valid arrives
// while occupied, and empties on the edge after the scheduler frees it.
module resp_fifo_wr_sched_resp_slot #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  input  logic         free_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         ovf_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         ovf_q;

  // A valid arriving in the freeing cycle still sees the slot occupied and is dropped.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q) begin
      if (free_i) valid_d = 1'b0;
    end else if (vld_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= vld_i & valid_q;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/resp_fifo_wr_sched.sv
// Round-robin scheduler draining the RF (1-byte) and ALU (2-byte) response slots into the
// TX FIFO write port; an ALU result is always written low byte then high byte back to back.
module resp_fifo_wr_sched
  import resp_fifo_wr_sched_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH    = 8,
  parameter int unsigned ALU_DATA_WIDTH = 16
) (
  input logic                 CLK,
  input logic                 RST,
  resp_fifo_wr_sched_if.slave bus
);

  if (ALU_DATA_WIDTH != 2 * FRAME_WIDTH) begin : g_width_check
    $error("ALU_DATA_WIDTH must equal 2*FRAME_WIDTH");
  end

  logic [1:0]                state_q, state_d;
  logic                      ptr_q, ptr_d;
  logic                      rf_valid, alu_valid;
  logic                      rf_free, alu_free;
  logic                      rf_ovf, alu_ovf;
  logic [FRAME_WIDTH-1:0]    rf_data;
  logic [ALU_DATA_WIDTH-1:0] alu_data;
  logic                      wr_inc;

  resp_fifo_wr_sched_resp_slot #(.W(FRAME_WIDTH)) u_rf_slot (
    .CLK     (CLK),
    .RST     (RST),
    .vld_i   (bus.RF_VLD),
    .data_i  (bus.RF_DATA),
    .free_i  (rf_free),
    .valid_o (rf_valid),
    .data_o  (rf_data),
    .ovf_o   (rf_ovf)
  );

  resp_fifo_wr_sched_resp_slot #(.W(ALU_DATA_WIDTH)) u_alu_slot (
    .CLK     (CLK),
    .RST     (RST),
    .vld_i   (bus.ALU_VLD),
    .data_i  (bus.ALU_DATA),
    .free_i  (alu_free),
    .valid_o (alu_valid),
    .data_o  (alu_data),
    .ovf_o   (alu_ovf)
  );

  assign wr_inc = (state_q != StIdle) & ~bus.FIFO_FULL;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rf_free  = 1'b0;
    alu_free = 1'b0;
    unique case (state_q)
      StIdle: state_d = idle_pick(rf_valid, alu_valid, ptr_q);
      StSendRf: begin
        if (wr_inc) begin
          rf_free = 1'b1;
          ptr_d   = PtrRf;
          state_d = alu_valid ? StSendAluLo : StIdle;
        end
      end
      StSendAluLo: begin
        if (wr_inc) state_d = StSendAluHi;
      end
      StSendAluHi: begin
        if (wr_inc) begin
          alu_free = 1'b1;
          ptr_d    = PtrAlu;
          state_d  = rf_valid ? StSendRf : StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      ptr_q   <= PtrAlu;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    bus.WR_DATA = '0;
    unique case (state_q)
      StIdle:      bus.WR_DATA = '0;
      StSendRf:    bus.WR_DATA = rf_data;
      StSendAluLo: bus.WR_DATA = alu_data[FRAME_WIDTH-1:0];
      StSendAluHi: bus.WR_DATA = alu_data[ALU_DATA_WIDTH-1:FRAME_WIDTH];
    endcase
  end

  assign bus.WR_INC   = wr_inc;
  assign bus.RF_BUSY  = rf_valid;
  assign bus.ALU_BUSY = alu_valid;
  assign bus.OVF_ERR  = rf_ovf | alu_ovf;

endmodule

// File: tb/tb_resp_fifo_wr_sched.sv
// Bench for resp_fifo_wr_sched: cycle-vector table, hand-written stall/reset sequences, and a
// randomized run checked against a byte-queue reference model.
module tb_resp_fifo_wr_sched;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  resp_fifo_wr_sched_if #(.FRAME_WIDTH(8), .ALU_DATA_WIDTH(16)) bus ();

  resp_fifo_wr_sched #(.FRAME_WIDTH(8), .ALU_DATA_WIDTH(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  always @(negedge CLK) if (bus.WR_INC === 1'b1) wr_cnt++;

  typedef struct {
    logic        rv;
    logic [7:0]  rd;
    logic        av;
    logic [15:0] ad;
    logic        full;
    logic [11:0] exp;
  } vec_t;

  function automatic logic [11:0] pk(input logic inc, input logic [7:0] d, input logic rb,
                                     input logic ab, input logic ov);
    return {inc, d, rb, ab, ov};
  endfunction

  function automatic vec_t mk(input logic rv, input logic [7:0] rd, input logic av,
                              input logic [15:0] ad, input logic [11:0] exp);
    vec_t v;
    v.rv = rv; v.rd = rd; v.av = av; v.ad = ad; v.full = 1'b0; v.exp = exp;
    return v;
  endfunction

  function automatic logic [11:0] obs();
    return {bus.WR_INC, bus.WR_DATA, bus.RF_BUSY, bus.ALU_BUSY, bus.OVF_ERR};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got inc=%b data=%h rf_busy=%b alu_busy=%b ovf=%b, expected inc=%b data=%h rf_busy=%b alu_busy=%b ovf=%b",
               name, act[11], act[10:3], act[2], act[1], act[0],
               exp[11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic rv, input logic [7:0] rd, input logic av,
                       input logic [15:0] ad, input logic full);
    bus.RF_VLD = rv; bus.RF_DATA = rd; bus.ALU_VLD = av; bus.ALU_DATA = ad;
    bus.FIFO_FULL = full;
  endtask

  // One cycle: drive after the rising edge, check outputs on the falling edge.
  task automatic cyc(input logic rv, input logic [7:0] rd, input logic av, input logic [15:0] ad,
                     input logic full, input string name, input logic [11:0] exp);
    @(posedge CLK); #1;
    drive(rv, rd, av, ad, full);
    @(negedge CLK);
    check(name, obs(), exp);
  endtask

  vec_t tbl[30];

  // Reference model state: slot contents plus the byte queue of the frame in flight.
  logic       m_rf_v, m_alu_v, m_last, m_ovf, q_src;
  logic [7:0] m_rf_d;
  logic [15:0] m_alu_d;
  logic [7:0] q[$];

  task automatic model_step(input logic rv, input logic [7:0] rd, input logic av,
                            input logic [15:0] ad, input logic full);
    logic old_rf, old_alu, el_rf, el_alu;
    old_rf = m_rf_v; old_alu = m_alu_v; el_rf = old_rf; el_alu = old_alu;
    if (q.size() > 0 && !full) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        if (q_src == 1'b0) begin m_rf_v = 1'b0; el_rf = 1'b0; m_last = 1'b0; end
        else begin m_alu_v = 1'b0; el_alu = 1'b0; m_last = 1'b1; end
      end
    end
    if (q.size() == 0) begin
      if (el_rf && (!el_alu || m_last == 1'b1)) begin
        q_src = 1'b0; q.push_back(m_rf_d);
      end else if (el_alu) begin
        q_src = 1'b1; q.push_back(m_alu_d[7:0]); q.push_back(m_alu_d[15:8]);
      end
    end
    m_ovf = (rv && old_rf) || (av && old_alu);
    if (rv && !old_rf) begin m_rf_v = 1'b1; m_rf_d = rd; end
    if (av && !old_alu) begin m_alu_v = 1'b1; m_alu_d = ad; end
  endtask

  initial begin
    int base;
    logic [11:0] exp;
    logic rv, av, full;
    logic [7:0] rd;
    logic [15:0] ad;

    // Single RF, single ALU, two ties with opposite pointer, overflows incl. accept-cycle VLD.
    tbl[0]  = mk(1, 8'h5A, 0, 16'h0000, pk(0, 8'h00, 0, 0, 0));
    tbl[1]  = mk(0, 8'h00, 0, 16'h0000, pk(0, 8'h00, 1, 0, 0));
    tbl[2]  = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'h5A, 1, 0, 0));
    tbl[3]  = mk(0, 8'h00, 0, 16'h0000, pk(0, 8'h00, 0, 0, 0));
    tbl[4]  = mk(0, 8'h00, 1, 16'hBEEF, pk(0, 8'h00, 0, 0, 0));
    tbl[5]  = mk(0, 8'h00, 0, 16'h0000, pk(0, 8'h00, 0, 1, 0));
    tbl[6]  = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'hEF, 0, 1, 0));
    tbl[7]  = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'hBE, 0, 1, 0));
    tbl[8]  = mk(1, 8'h11, 1, 16'h2233, pk(0, 8'h00, 0, 0, 0));
    tbl[9]  = mk(0, 8'h00, 0, 16'h0000, pk(0, 8'h00, 1, 1, 0));
    tbl[10] = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'h11, 1, 1, 0));
    tbl[11] = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'h33, 0, 1, 0));
    tbl[12] = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'h22, 0, 1, 0));
    tbl[13] = mk(1, 8'h44, 0, 16'h0000, pk(0, 8'h00, 0, 0, 0));
    tbl[14] = mk(0, 8'h00, 0, 16'h0000, pk(0, 8'h00, 1, 0, 0));
    tbl[15] = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'h44, 1, 0, 0));
    tbl[16] = mk(1, 8'h11, 1, 16'h2233, pk(0, 8'h00, 0, 0, 0));
    tbl[17] = mk(0, 8'h00, 0, 16'h0000, pk(0, 8'h00, 1, 1, 0));
    tbl[18] = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'h33, 1, 1, 0));
    tbl[19] = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'h22, 1, 1, 0));
    tbl[20] = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'h11, 1, 0, 0));
    tbl[21] = mk(1, 8'h55, 0, 16'h0000, pk(0, 8'h00, 0, 0, 0));
    tbl[22] = mk(1, 8'h77, 0, 16'h0000, pk(0, 8'h00, 1, 0, 0));
    tbl[23] = mk(0, 8'h00, 0, 16'h0000, pk(1, 8'h55, 1, 0, 1));
    tbl[24] = mk(0, 8'h00, 0, 16'h0000, pk(0, 8'h00, 0, 0, 0));
    tbl[25] = mk(1, 8'h66, 0, 16'h0000, pk(0, 8'h00, 0, 0, 0));
    tbl[26] = mk(0, 8'h00, 0, 16'h0000, pk(0, 8'h00, 1, 0, 0));
    tbl[27] = mk(1, 8'h99, 0, 16'h0000, pk(1, 8'h66, 1, 0, 0));
    tbl[28] = mk(0, 8'h00, 0, 16'h0000, pk(0, 8'h00, 0, 0, 1));
    tbl[29] = mk(0, 8'h00, 0, 16'h0000, pk(0, 8'h00, 0, 0, 0));

    drive(0, 8'h00, 0, 16'h0000, 0);
    repeat (2) @(negedge CLK);
    check("reset", obs(), pk(0, 8'h00, 0, 0, 0));
    RST = 1'b1;

    for (int i = 0; i < 30; i++) begin
      cyc(tbl[i].rv, tbl[i].rd, tbl[i].av, tbl[i].ad, tbl[i].full,
          $sformatf("vec%0d", i), tbl[i].exp);
    end

    // Stall for five cycles on the high byte of an ALU result.
    base = wr_cnt;
    cyc(0, 8'h00, 1, 16'hBEEF, 0, "stall_req", pk(0, 8'h00, 0, 0, 0));
    cyc(0, 8'h00, 0, 16'h0000, 0, "stall_cap", pk(0, 8'h00, 0, 1, 0));
    cyc(0, 8'h00, 0, 16'h0000, 0, "stall_lo", pk(1, 8'hEF, 0, 1, 0));
    for (int i = 0; i < 5; i++)
      cyc(0, 8'h00, 0, 16'h0000, 1, $sformatf("stall_hi%0d", i), pk(0, 8'hBE, 0, 1, 0));
    cyc(0, 8'h00, 0, 16'h0000, 0, "stall_rel", pk(1, 8'hBE, 0, 1, 0));
    cyc(0, 8'h00, 0, 16'h0000, 0, "stall_done", pk(0, 8'h00, 0, 0, 0));
    n_checks++;
    if (wr_cnt - base != 2) begin
      n_fail++;
      $display("FAIL stall_count: got %0d writes, expected 2", wr_cnt - base);
    end

    // Reset between the low and high byte abandons the frame.
    base = wr_cnt;
    cyc(0, 8'h00, 1, 16'hA1B2, 0, "rst_req", pk(0, 8'h00, 0, 0, 0));
    cyc(0, 8'h00, 0, 16'h0000, 0, "rst_cap", pk(0, 8'h00, 0, 1, 0));
    cyc(0, 8'h00, 0, 16'h0000, 0, "rst_lo", pk(1, 8'hB2, 0, 1, 0));
    #1 RST = 1'b0;
    #1 check("rst_async", obs(), pk(0, 8'h00, 0, 0, 0));
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(0, 8'h00, 0, 16'h0000, 0, $sformatf("rst_quiet%0d", i), pk(0, 8'h00, 0, 0, 0));
    cyc(1, 8'h3C, 0, 16'h0000, 0, "rst_new_req", pk(0, 8'h00, 0, 0, 0));
    cyc(0, 8'h00, 0, 16'h0000, 0, "rst_new_cap", pk(0, 8'h00, 1, 0, 0));
    cyc(0, 8'h00, 0, 16'h0000, 0, "rst_new_wr", pk(1, 8'h3C, 1, 0, 0));
    cyc(0, 8'h00, 0, 16'h0000, 0, "rst_new_idle", pk(0, 8'h00, 0, 0, 0));
    n_checks++;
    if (wr_cnt - base != 2) begin
      n_fail++;
      $display("FAIL rst_count: got %0d writes, expected 2", wr_cnt - base);
    end

    // Randomized traffic against the reference model, starting from a fresh reset.
    @(negedge CLK);
    RST = 1'b0;
    drive(0, 8'h00, 0, 16'h0000, 0);
    @(negedge CLK);
    RST = 1'b1;
    m_rf_v = 0; m_alu_v = 0; m_last = 1'b1; m_ovf = 0; q_src = 0;
    m_rf_d = '0; m_alu_d = '0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      rv = ($urandom_range(0, 3) == 0);
      rd = 8'($urandom);
      av = ($urandom_range(0, 4) == 0);
      ad = 16'($urandom);
      full = ($urandom_range(0, 2) == 0);
      exp = pk((q.size() > 0) && !full, (q.size() > 0) ? q[0] : 8'h00, m_rf_v, m_alu_v, m_ovf);
      cyc(rv, rd, av, ad, full, $sformatf("rand%0d", c), exp);
      model_step(rv, rd, av, ad, full);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
